// File: rtl/sd_match_counter_if.sv
// Snapshot read port of sd_match_counter: request/ack from the consumer,
// valid/count from the counter.
interface sd_match_counter_if #(
   parameter int CNT_W = 8
);
   logic             rd_req;
   logic             snap_ack;
   logic             snap_valid;
   logic [CNT_W-1:0] snap_cnt;

   // The consumer raises rd_req to request a snapshot. snap_valid then marks a held
   // count. snap_cnt is stable while snap_valid=1. snap_ack=1 with snap_valid=1
   // releases the snapshot on the next edge. snap_ack with snap_valid=0 is ignored.
   modport master (
      output rd_req,
      output snap_ack,
      input  snap_valid,
      input  snap_cnt
   );

   modport slave (
      input  rd_req,
      input  snap_ack,
      output snap_valid,
      output snap_cnt
   );
endinterface

// File: rtl/sd_match_counter.sv
// Counts rising edges of the sequence-detector flag and hands the count out through
// a snapshot handshake. SD_GAP_TRACK_EN adds tracking of the minimum gap between detections.
module sd_match_counter #(
   parameter int CNT_W  = 8,
   parameter int THRESH = 4,
   parameter int GAP_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              det,
   input  logic              en,
   sd_match_counter_if.slave snap,
   output logic              thresh_hit,
   output logic              ovf,
   output logic [GAP_W-1:0]  min_gap,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state;
   state_t           state_nxt;
   logic             det_q;
   logic [CNT_W-1:0] live;
   logic [CNT_W-1:0] live_inc;
   logic [CNT_W-1:0] snap_sum;
   logic [CNT_W-1:0] snap_cnt_q;
   logic             live_sat;
   logic             evt;
   logic             accept;

   assign evt      = det & ~det_q & en;
   assign live_sat = (live == CNT_MAX);
   assign live_inc = live + CNT_W'(1);
   // A detection on the accept cycle lands in the snapshot, not in the new live count.
   assign snap_sum = (evt && !live_sat) ? live_inc : live;
   assign accept   = snap.rd_req && !snap.snap_valid && (state != S_HOLD);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept)  state_nxt = S_HOLD;
            else if (en) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (accept)   state_nxt = S_HOLD;
            else if (!en) state_nxt = S_IDLE;
         end
         S_HOLD: begin
            if (snap.snap_ack) state_nxt = en ? S_RUN : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      snap.snap_valid = (state == S_HOLD);
      snap.snap_cnt   = snap_cnt_q;
      fsm_state       = state;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         det_q      <= 1'b0;
         live       <= '0;
         snap_cnt_q <= '0;
         thresh_hit <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         det_q <= det;
         if (accept) begin
            snap_cnt_q <= snap_sum;
            live       <= '0;
            thresh_hit <= 1'b0;
            ovf        <= 1'b0;
         end else if (evt) begin
            if (live_sat) begin
               ovf <= 1'b1;
            end else begin
               live <= live_inc;
               if (live_inc == THRESH_V) thresh_hit <= 1'b1;
            end
         end
      end
   end

`ifdef SD_GAP_TRACK_EN
   localparam logic [GAP_W-1:0] GAP_MAX = '1;

   logic [GAP_W-1:0] gap;
   logic [GAP_W-1:0] min_gap_q;
   logic             first_pend;

   // The first detection after reset or accept only restarts the timer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gap        <= GAP_MAX;
         min_gap_q  <= GAP_MAX;
         first_pend <= 1'b1;
      end else begin
         if (evt)                 gap <= GAP_W'(1);
         else if (gap != GAP_MAX) gap <= gap + GAP_W'(1);

         if (accept) begin
            min_gap_q  <= GAP_MAX;
            first_pend <= 1'b1;
         end else if (evt) begin
            first_pend <= 1'b0;
            if (!first_pend && (gap < min_gap_q)) min_gap_q <= gap;
         end
      end
   end

   assign min_gap = min_gap_q;
`else
   assign min_gap = '1;
`endif

endmodule
